// File: rtl/serdes_rx_frame_decoder_if.sv
// Stream of decoded frame words leaving the 64b/66b frame decoder.
// The stream has no backpressure: a word is present whenever tvalid is high.
interface serdes_rx_frame_decoder_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/serdes_rx_frame_decoder.sv
// Turns unscrambled 64b/66b blocks into a frame word stream. A one-word hold register
// delays each data block by a cycle so that the word before a terminate can carry tlast.
module serdes_rx_frame_decoder #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    serdes_data,
  input  logic [HDR_WIDTH-1:0]     serdes_hdr,
  input  logic                     block_lock,
  serdes_rx_frame_decoder_if.master m_axis,
  output logic                     in_frame,
  output logic [31:0]              frame_count,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  localparam logic [HDR_WIDTH-1:0] HDR_DATA   = 2'b10;
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL   = 2'b01;
  localparam logic [7:0]           TYPE_START = 8'h78;
  localparam logic [7:0]           TYPE_IDLE  = 8'h1E;
  localparam logic [55:0]          PREAMBLE   = 56'hD5_5555_5555_5555;
  localparam logic [3:0]           NOT_TERM   = 4'd8;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t                  state, state_n;
  logic                    hold_vld, hold_vld_n;
  logic                    hold_last, hold_last_n;
  logic                    hold_user, hold_user_n;
  logic [DATA_WIDTH-1:0]   hold_data, hold_data_n;
  logic [KEEP_W-1:0]       hold_keep, hold_keep_n;

  logic                    emit, emit_last, emit_user;
  logic [DATA_WIDTH-1:0]   emit_data;
  logic [KEEP_W-1:0]       emit_keep;
  logic                    frame_inc, err_inc, abort;
  logic [7:0]              blk_type;
  logic [3:0]              tlen;

  // Terminate control types map to the number of trailing data bytes they carry.
  function automatic logic [3:0] term_len(input logic [7:0] t);
    case (t)
      8'h87:   return 4'd0;
      8'h99:   return 4'd1;
      8'hAA:   return 4'd2;
      8'hB4:   return 4'd3;
      8'hCC:   return 4'd4;
      8'hD2:   return 4'd5;
      8'hE1:   return 4'd6;
      8'hFF:   return 4'd7;
      default: return NOT_TERM;
    endcase
  endfunction

  function automatic logic [KEEP_W-1:0] keep_mask(input logic [2:0] n);
    logic [KEEP_W:0] m;
    m = ({{KEEP_W{1'b0}}, 1'b1} << n) - {{KEEP_W{1'b0}}, 1'b1};
    return m[KEEP_W-1:0];
  endfunction

  assign blk_type = serdes_data[7:0];
  assign tlen     = term_len(blk_type);
  assign in_frame = (state == IN_FRAME);

  always_comb begin
    state_n     = state;
    hold_vld_n  = hold_vld;
    hold_last_n = hold_last;
    hold_user_n = hold_user;
    hold_data_n = hold_data;
    hold_keep_n = hold_keep;
    emit        = 1'b0;
    emit_data   = '0;
    emit_keep   = '0;
    emit_last   = 1'b0;
    emit_user   = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    abort       = 1'b0;

    // A short last word left behind by a terminate drains here, independent of the input,
    // so a start block arriving on the same cycle is still decoded below.
    if (hold_vld && hold_last) begin
      emit       = 1'b1;
      emit_data  = hold_data;
      emit_keep  = hold_keep;
      emit_last  = 1'b1;
      emit_user  = hold_user;
      frame_inc  = 1'b1;
      hold_vld_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (block_lock) begin
          if (serdes_hdr == HDR_CTRL) begin
            if (blk_type == TYPE_START) begin
              if (serdes_data[DATA_WIDTH-1:8] == PREAMBLE) begin
                state_n    = IN_FRAME;
                hold_vld_n = 1'b0;
              end else begin
                err_inc = 1'b1;
              end
            end else if (blk_type != TYPE_IDLE) begin
              err_inc = 1'b1;
            end
          end else if (serdes_hdr != HDR_DATA) begin
            err_inc = 1'b1;
          end
        end
      end

      IN_FRAME: begin
        if (!block_lock) begin
          abort = 1'b1;
        end else if (serdes_hdr == HDR_DATA) begin
          if (hold_vld) begin
            emit      = 1'b1;
            emit_data = hold_data;
            emit_keep = hold_keep;
            emit_user = hold_user;
          end
          hold_data_n = serdes_data;
          hold_keep_n = '1;
          hold_last_n = 1'b0;
          hold_user_n = 1'b0;
          hold_vld_n  = 1'b1;
        end else if (serdes_hdr == HDR_CTRL && tlen != NOT_TERM) begin
          if (tlen == 4'd0) begin
            if (hold_vld) begin
              emit      = 1'b1;
              emit_data = hold_data;
              emit_keep = hold_keep;
              emit_last = 1'b1;
              emit_user = hold_user;
              frame_inc = 1'b1;
            end else begin
              err_inc = 1'b1;
            end
            hold_vld_n = 1'b0;
          end else begin
            if (hold_vld) begin
              emit      = 1'b1;
              emit_data = hold_data;
              emit_keep = hold_keep;
              emit_user = hold_user;
            end
            hold_data_n = serdes_data >> 8;
            hold_keep_n = keep_mask(tlen[2:0]);
            hold_last_n = 1'b1;
            hold_user_n = 1'b0;
            hold_vld_n  = 1'b1;
          end
          state_n = IDLE;
        end else begin
          abort = 1'b1;
        end

        // An abort closes the frame with whatever is held; an empty frame gets a keep-0 marker word.
        if (abort) begin
          emit       = 1'b1;
          emit_data  = hold_vld ? hold_data : '0;
          emit_keep  = hold_vld ? hold_keep : '0;
          emit_last  = 1'b1;
          emit_user  = 1'b1;
          err_inc    = 1'b1;
          hold_vld_n = 1'b0;
          state_n    = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_vld      <= 1'b0;
      hold_last     <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      frame_count   <= '0;
      err_count     <= '0;
    end else begin
      state         <= state_n;
      hold_vld      <= hold_vld_n;
      hold_last     <= hold_last_n;
      m_axis.tvalid <= emit;
      m_axis.tdata  <= emit_data;
      m_axis.tkeep  <= emit_keep;
      m_axis.tlast  <= emit_last;
      m_axis.tuser  <= emit_user;
      if (frame_inc) frame_count <= frame_count + 32'd1;
      if (err_inc && err_count != {ERR_CNT_WIDTH{1'b1}})
        err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

  // Hold payload is only ever read while hold_vld is set, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_data <= hold_data_n;
    hold_keep <= hold_keep_n;
    hold_user <= hold_user_n;
  end

endmodule
